// File: rtl/seg_readback.sv
`default_nettype none
// ============================================================================
// seg_readback : glitch-filtered readback, BCD decode and step check of a
//                two-digit seven-segment bus.   Revision 1.0
// ============================================================================
module seg_readback #(
   parameter int STABLE_CYCLES = 16,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8:0]           led_1,
   input  logic [8:0]           led_2,
   output logic                 valid,
   output logic [3:0]           units,
   output logic [3:0]           tens,
   output logic [6:0]           value,
   output logic                 update,
   output logic                 bad_code,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int              CNT_W     = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_pre = CNT_W'(STABLE_CYCLES - 2);

   typedef enum logic [1:0] {S_INIT, S_TRACK, S_BAD} state_t;

   // Returns {decoded_ok, digit}; anything outside the table is a bad code.
   function automatic logic [4:0] f_decode(input logic [8:0] pat);
      case (pat)
         9'h03F:  return {1'b1, 4'd0};
         9'h006:  return {1'b1, 4'd1};
         9'h05B:  return {1'b1, 4'd2};
         9'h04F:  return {1'b1, 4'd3};
         9'h066:  return {1'b1, 4'd4};
         9'h06D:  return {1'b1, 4'd5};
         9'h07D:  return {1'b1, 4'd6};
         9'h007:  return {1'b1, 4'd7};
         9'h07F:  return {1'b1, 4'd8};
         9'h06F:  return {1'b1, 4'd9};
         default: return 5'd0;
      endcase
   endfunction

   logic [17:0]          cand_q, acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 acc_pend_q;
   state_t               state_q, state_d;
   logic                 valid_q, valid_d, update_q, update_d;
   logic                 bad_q, bad_d, step_err_q, step_err_d;
   logic [3:0]           units_q, units_d, tens_q, tens_d;
   logic [6:0]           value_q, value_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;

   logic [17:0] w_sample;
   logic        w_same, w_accept, w_good, w_legal, w_err_inc;
   logic [4:0]  w_u, w_t;
   logic [6:0]  w_v, w_next_p;

   assign w_sample = {led_2, led_1};
   assign w_same   = (w_sample == cand_q);
   // Fires on the edge where the counter would reach its ceiling.
   assign w_accept = w_same && (cnt_q == c_cnt_pre) && (cand_q != acc_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q     <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         acc_pend_q <= 1'b0;
      end else begin
         if (!w_same) begin
            cand_q <= w_sample;
            cnt_q  <= '0;
         end else if (cnt_q != c_cnt_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         acc_pend_q <= w_accept;
         if (w_accept) acc_q <= cand_q;
      end
   end

   assign w_u      = f_decode(acc_q[8:0]);
   assign w_t      = f_decode(acc_q[17:9]);
   assign w_good   = w_u[4] & w_t[4];
   assign w_v      = 7'(w_t[3:0]) * 7'd10 + 7'(w_u[3:0]);
   assign w_next_p = (value_q == 7'd99) ? 7'd0 : value_q + 7'd1;
   assign w_legal  = (w_v == w_next_p) || (w_v == 7'd0);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      units_d    = units_q;
      tens_d     = tens_q;
      value_d    = value_q;
      bad_d      = bad_q;
      update_d   = 1'b0;
      step_err_d = 1'b0;
      w_err_inc  = 1'b0;
      if (acc_pend_q) begin
         if (!w_good) begin
            if (state_q != S_BAD) begin
               state_d   = S_BAD;
               valid_d   = 1'b0;
               bad_d     = 1'b1;
               w_err_inc = 1'b1;
            end
         end else begin
            // Only an established TRACK baseline is step-checked.
            if ((state_q == S_TRACK) && !w_legal) begin
               step_err_d = 1'b1;
               w_err_inc  = 1'b1;
            end
            state_d  = S_TRACK;
            valid_d  = 1'b1;
            bad_d    = 1'b0;
            update_d = 1'b1;
            units_d  = w_u[3:0];
            tens_d   = w_t[3:0];
            value_d  = w_v;
         end
      end
      err_d = (w_err_inc && (err_q != '1)) ? err_q + ERR_CNT_W'(1) : err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_INIT;
         valid_q    <= 1'b0;
         units_q    <= '0;
         tens_q     <= '0;
         value_q    <= '0;
         bad_q      <= 1'b0;
         update_q   <= 1'b0;
         step_err_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         units_q    <= units_d;
         tens_q     <= tens_d;
         value_q    <= value_d;
         bad_q      <= bad_d;
         update_q   <= update_d;
         step_err_q <= step_err_d;
         err_q      <= err_d;
      end
   end

   assign valid     = valid_q;
   assign units     = units_q;
   assign tens      = tens_q;
   assign value     = value_q;
   assign update    = update_q;
   assign bad_code  = bad_q;
   assign step_err  = step_err_q;
   assign err_count = err_q;

endmodule
`default_nettype wire
